// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - three-voice note allocator and sample mixer; VOICE_STEAL_EN reuses the oldest voice when all are busy
module voice_allocator #(
    parameter int SAMPLE_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               play,
    input  logic               load_new_note,
    input  logic [5:0]         note_in,
    input  logic [5:0]         duration_in,
    input  logic               generate_next_sample,
    input  logic [2:0]         voice_busy,
    input  logic [47:0]        voice_sample,
    input  logic [2:0]         voice_sample_ready,
    output logic [2:0]         voice_load,
    output logic [5:0]         voice_note,
    output logic [5:0]         voice_duration,
    output logic [2:0]         voice_gen,
    output logic signed [15:0] sample_out,
    output logic               new_sample_ready,
    output logic               note_dropped
);

    localparam int TW = $clog2(SAMPLE_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, MIX, OUT} seq_state_t;

    // ---------------- allocation ----------------
    logic [2:0] load_d1;
    logic [1:0] age_old, age_mid, age_young;
    logic [1:0] age_old_n, age_mid_n, age_young_n;
    logic [2:0] recent, free, lowest, target;
    logic [1:0] tgt_idx;
    logic       drop;

    // A player raises voice_busy a couple of cycles after its load pulse,
    // so voices loaded this cycle or last are treated as taken.
    always_comb begin
        recent = voice_load | load_d1;
        free   = ~voice_busy & ~recent;
        if (free[0])      lowest = 3'b001;
        else if (free[1]) lowest = 3'b010;
        else if (free[2]) lowest = 3'b100;
        else              lowest = 3'b000;
`ifdef VOICE_STEAL_EN
        target = (|free) ? lowest : (3'b001 << age_old);
        drop   = 1'b0;
`else
        target = lowest;
        drop   = ~(|free);
`endif
        case (target)
            3'b010:  tgt_idx = 2'd1;
            3'b100:  tgt_idx = 2'd2;
            default: tgt_idx = 2'd0;
        endcase
    end

    always_comb begin
        age_old_n   = age_old;
        age_mid_n   = age_mid;
        age_young_n = age_young;
        if (age_old == tgt_idx) begin
            age_old_n   = age_mid;
            age_mid_n   = age_young;
            age_young_n = tgt_idx;
        end else if (age_mid == tgt_idx) begin
            age_mid_n   = age_young;
            age_young_n = tgt_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            voice_load     <= 3'b000;
            voice_note     <= 6'd0;
            voice_duration <= 6'd0;
            note_dropped   <= 1'b0;
            load_d1        <= 3'b000;
            age_old        <= 2'd2;
            age_mid        <= 2'd1;
            age_young      <= 2'd0;
        end else begin
            voice_load   <= 3'b000;
            note_dropped <= 1'b0;
            load_d1      <= voice_load;
            if (load_new_note && play) begin
                note_dropped <= drop;
                if (target != 3'b000) begin
                    voice_load     <= target;
                    voice_note     <= note_in;
                    voice_duration <= duration_in;
                    age_old        <= age_old_n;
                    age_mid        <= age_mid_n;
                    age_young      <= age_young_n;
                end
            end
        end
    end

    // ---------------- sample sequencer ----------------
    seq_state_t        state, state_n;
    logic [1:0]        v, v_n;
    logic signed [17:0] acc, acc_n;
    logic [TW-1:0]     cnt, cnt_n;
    logic [2:0]        gen_n;
    logic              nsr_n;
    logic signed [15:0] out_n;
    logic [15:0]       cur_sample;
    logic signed [17:0] cur_ext;

    always_comb begin
        case (v)
            2'd1:    cur_sample = voice_sample[31:16];
            2'd2:    cur_sample = voice_sample[47:32];
            default: cur_sample = voice_sample[15:0];
        endcase
        cur_ext = {{2{cur_sample[15]}}, cur_sample};
    end

    always_comb begin
        state_n = state;
        v_n     = v;
        acc_n   = acc;
        cnt_n   = cnt;
        gen_n   = 3'b000;
        nsr_n   = 1'b0;
        out_n   = sample_out;
        case (state)
            IDLE: begin
                if (generate_next_sample) begin
                    state_n = REQ;
                    acc_n   = 18'sd0;
                    v_n     = 2'd0;
                end
            end
            REQ: begin
                cnt_n = '0;
                if (voice_busy[v]) begin
                    gen_n   = 3'b001 << v;
                    state_n = WAIT;
                end else if (v == 2'd2) begin
                    state_n = MIX;
                end else begin
                    v_n = v + 2'd1;
                end
            end
            WAIT: begin
                if (voice_sample_ready[v] || cnt == TW'(SAMPLE_TIMEOUT - 1)) begin
                    if (voice_sample_ready[v])
                        acc_n = acc + cur_ext;
                    if (v == 2'd2) begin
                        state_n = MIX;
                    end else begin
                        v_n     = v + 2'd1;
                        state_n = REQ;
                    end
                end else begin
                    cnt_n = cnt + TW'(1);
                end
            end
            MIX: begin
                if (acc > 18'sd32767)
                    acc_n = 18'sd32767;
                else if (acc < -18'sd32768)
                    acc_n = -18'sd32768;
                state_n = OUT;
            end
            OUT: begin
                out_n   = acc[15:0];
                nsr_n   = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            v                <= 2'd0;
            acc              <= 18'sd0;
            cnt              <= '0;
            voice_gen        <= 3'b000;
            new_sample_ready <= 1'b0;
            sample_out       <= 16'sd0;
        end else begin
            state            <= state_n;
            v                <= v_n;
            acc              <= acc_n;
            cnt              <= cnt_n;
            voice_gen        <= gen_n;
            new_sample_ready <= nsr_n;
            sample_out       <= out_n;
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - directed bench for voice_allocator with a simple note-player sample model
module tb_voice_allocator;

    logic               clk = 1'b0;
    logic               reset;
    logic               play;
    logic               load_new_note;
    logic [5:0]         note_in;
    logic [5:0]         duration_in;
    logic               generate_next_sample;
    logic [2:0]         voice_busy;
    logic [47:0]        voice_sample;
    logic [2:0]         voice_sample_ready;
    logic [2:0]         voice_load;
    logic [5:0]         voice_note;
    logic [5:0]         voice_duration;
    logic [2:0]         voice_gen;
    logic signed [15:0] sample_out;
    logic               new_sample_ready;
    logic               note_dropped;

    int errors = 0;
    int checks = 0;
    int pulses;
    int first_pulse;
    logic [2:0] gen_seen;
    logic [2:0] dead_mask = 3'b000;
    logic [2:0] gd0 = 3'b000;
    logic [2:0] gd1 = 3'b000;

    voice_allocator dut (
        .clk                  (clk),
        .reset                (reset),
        .play                 (play),
        .load_new_note        (load_new_note),
        .note_in              (note_in),
        .duration_in          (duration_in),
        .generate_next_sample (generate_next_sample),
        .voice_busy           (voice_busy),
        .voice_sample         (voice_sample),
        .voice_sample_ready   (voice_sample_ready),
        .voice_load           (voice_load),
        .voice_note           (voice_note),
        .voice_duration       (voice_duration),
        .voice_gen            (voice_gen),
        .sample_out           (sample_out),
        .new_sample_ready     (new_sample_ready),
        .note_dropped         (note_dropped)
    );

    always #5 clk = ~clk;

    // Player model: answers a voice_gen pulse with a one-cycle ready two cycles later.
    always @(posedge clk) begin
        #2;
        voice_sample_ready = gd1 & ~dead_mask;
        gd1 = gd0;
        gd0 = voice_gen;
    end

    task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task step();
        @(posedge clk);
        #1;
    endtask

    task do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task do_load(input logic [5:0] n, input logic [5:0] d);
        load_new_note = 1'b1;
        note_in       = n;
        duration_in   = d;
        step();
        load_new_note = 1'b0;
    endtask

    task run_seq(input int bound, input int regen_at);
        pulses      = 0;
        first_pulse = -1;
        gen_seen    = 3'b000;
        generate_next_sample = 1'b1;
        for (int i = 1; i <= bound; i++) begin
            step();
            generate_next_sample = (i == regen_at);
            if (new_sample_ready) begin
                pulses++;
                if (first_pulse < 0) first_pulse = i;
            end
            gen_seen |= voice_gen;
        end
    endtask

    initial begin
        reset = 1'b1; play = 1'b1; load_new_note = 1'b0; note_in = 6'd0; duration_in = 6'd0;
        generate_next_sample = 1'b0; voice_busy = 3'b000; voice_sample = 48'd0;
        voice_sample_ready = 3'b000;
        do_reset();
        check("rst_voice_load", 32'(voice_load), 32'd0);
        check("rst_voice_note", 32'(voice_note), 32'd0);
        check("rst_voice_gen", 32'(voice_gen), 32'd0);
        check("rst_sample_out", 32'($unsigned(sample_out)), 32'd0);
        check("rst_nsr", 32'(new_sample_ready), 32'd0);
        check("rst_dropped", 32'(note_dropped), 32'd0);

        // first note lands on voice 0
        do_load(6'd12, 6'd8);
        check("load0_voice", 32'(voice_load), 32'b001);
        check("load0_note", 32'(voice_note), 32'd12);
        check("load0_dur", 32'(voice_duration), 32'd8);
        step();
        check("load0_pulse_end", 32'(voice_load), 32'b000);

        voice_busy = 3'b001; repeat (3) step();
        do_load(6'd13, 6'd4);
        check("load1_voice", 32'(voice_load), 32'b010);
        voice_busy = 3'b011; repeat (3) step();
        do_load(6'd20, 6'd5);
        check("load2_voice", 32'(voice_load), 32'b100);
        check("load2_note", 32'(voice_note), 32'd20);
        voice_busy = 3'b111; repeat (3) step();
        do_load(6'd21, 6'd6);
`ifdef VOICE_STEAL_EN
        check("full_steal_voice", 32'(voice_load), 32'b001);
        check("full_steal_drop", 32'(note_dropped), 32'd0);
        check("full_steal_note", 32'(voice_note), 32'd21);
`else
        check("full_drop_voice", 32'(voice_load), 32'b000);
        check("full_drop_pulse", 32'(note_dropped), 32'd1);
        check("full_drop_note", 32'(voice_note), 32'd20);
`endif
        step();
        check("drop_pulse_end", 32'(note_dropped), 32'd0);

        // back-to-back loads with busy still low: recent-load window
        voice_busy = 3'b000;
        do_reset();
        do_load(6'd1, 6'd1);
        check("lag_a", 32'(voice_load), 32'b001);
        do_load(6'd2, 6'd1);
        check("lag_b", 32'(voice_load), 32'b010);
        do_load(6'd3, 6'd1);
        check("lag_c", 32'(voice_load), 32'b100);
        do_load(6'd4, 6'd1);
        check("lag_d_window_expired", 32'(voice_load), 32'b001);

        // play low ignores the note
        step(); step();
        play = 1'b0;
        do_load(6'd9, 6'd9);
        check("noplay_load", 32'(voice_load), 32'b000);
        check("noplay_drop", 32'(note_dropped), 32'd0);
        play = 1'b1;
        step(); step();

        // all voices idle: exact latency and ignored re-trigger
        voice_busy = 3'b000;
        run_seq(20, 2);
        check("idle_pulses", 32'(pulses), 32'd1);
        check("idle_latency", 32'(first_pulse), 32'd6);
        check("idle_no_gen", 32'(gen_seen), 32'd0);

        // positive saturation
        voice_busy   = 3'b111;
        voice_sample = {16'hEC78, 16'h2710, 16'h7530};
        run_seq(40, 0);
        check("possat_pulses", 32'(pulses), 32'd1);
        check("possat_latency", 32'(first_pulse), 32'd15);
        check("possat_out", 32'($unsigned(sample_out)), 32'h7FFF);
        check("possat_gen", 32'(gen_seen), 32'b111);

        // negative saturation
        voice_sample = {16'h1388, 16'hD8F0, 16'h8AD0};
        run_seq(40, 0);
        check("negsat_pulses", 32'(pulses), 32'd1);
        check("negsat_out", 32'($unsigned(sample_out)), 32'h8000);

        // voice 1 never answers: timeout substitutes zero
        voice_busy = 3'b010;
        dead_mask  = 3'b010;
        run_seq(300, 0);
        check("tmo_pulses", 32'(pulses), 32'd1);
        check("tmo_latency", 32'(first_pulse), 32'd261);
        check("tmo_out", 32'($unsigned(sample_out)), 32'd0);

        // reset in WAIT after a nonzero output
        voice_busy   = 3'b001;
        dead_mask    = 3'b000;
        voice_sample = {16'd0, 16'd0, 16'h8000};
        run_seq(20, 0);
        check("pre_rst_out", 32'($unsigned(sample_out)), 32'h8000);
        voice_busy = 3'b010;
        dead_mask  = 3'b010;
        generate_next_sample = 1'b1;
        step();
        generate_next_sample = 1'b0;
        repeat (8) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_out", 32'($unsigned(sample_out)), 32'd0);
        pulses = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (new_sample_ready) pulses++;
        end
        check("midrst_no_pulse", 32'(pulses), 32'd0);

        voice_busy   = 3'b001;
        dead_mask    = 3'b000;
        voice_sample = {16'd0, 16'd0, 16'd1234};
        run_seq(30, 0);
        check("post_rst_pulses", 32'(pulses), 32'd1);
        check("post_rst_latency", 32'(first_pulse), 32'd9);
        check("post_rst_out", 32'($unsigned(sample_out)), 32'd1234);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
